// File: rtl/fault_trigger_sequencer_if.sv
// Request/status bundle between a trigger requester and the fault trigger sequencer.
// The sequencer takes the slave modport; the requester (or bench) takes master.
interface fault_trigger_sequencer_if #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             req_valid;
  logic [ID_W-1:0]  req_id;
  logic             req_ready;
  logic             flush;
  logic             logic_reset;
  logic             fault_in;
  logic             busy;
  logic [ID_W-1:0]  active_id;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [LVL_W-1:0] level;

  modport master (
    output req_valid, req_id, flush,
    input  req_ready, logic_reset, fault_in, busy, active_id, done, done_id, level
  );

  modport slave (
    input  req_valid, req_id, flush,
    output req_ready, logic_reset, fault_in, busy, active_id, done, done_id, level
  );
endinterface

// File: rtl/fault_trigger_sequencer.sv
// Queues trigger requests and plays each one out on a faulty gate as
// logic_reset pulse, settle wait, fault_in pulse, hold wait, done.
module fault_trigger_sequencer #(
  parameter int DEPTH      = 4,
  parameter int ID_W       = 4,
  parameter int SETTLE_CYC = 2,
  parameter int HOLD_CYC   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  fault_trigger_sequencer_if.slave  bus
);
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [LVL_W-1:0] FULL_LVL    = LVL_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, FIRE, HOLD} state_t;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             req_ready_q, req_ready_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  active_id_q, active_id_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic             logic_reset_q, logic_reset_d;
  logic             fault_in_q, fault_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             push, pop;

  always_comb begin
    // Readiness follows the registered level only, so a same-cycle pop never opens a slot.
    push = bus.req_valid && req_ready_q && !bus.flush;
    pop  = (state_q == IDLE) && (level_q != '0) && !bus.flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !push) level_d = level_q - LVL_W'(1);
    end
    req_ready_d = (level_d != FULL_LVL);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_id_d   = active_id_q;
    logic_reset_d = 1'b0;
    fault_in_d    = 1'b0;
    done_d        = 1'b0;
    done_id_d     = '0;
    if (bus.flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      active_id_d = '0;
    end else begin
      // Gate pulses are registered from the state they belong to, so they trail it by one cycle.
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_d     = CLEAR;
            active_id_d = mem_q[rd_ptr_q];
          end
        end
        CLEAR: begin
          logic_reset_d = 1'b1;
          state_d       = SETTLE;
          cnt_d         = '0;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) state_d = FIRE;
          else                      cnt_d   = cnt_q + CNT_W'(1);
        end
        FIRE: begin
          fault_in_d = 1'b1;
          state_d    = HOLD;
          cnt_d      = '0;
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            done_d      = 1'b1;
            done_id_d   = active_id_q;
            state_d     = IDLE;
            active_id_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      req_ready_q   <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      active_id_q   <= '0;
      done_id_q     <= '0;
      logic_reset_q <= 1'b0;
      fault_in_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      req_ready_q   <= req_ready_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_id_q   <= active_id_d;
      done_id_q     <= done_id_d;
      logic_reset_q <= logic_reset_d;
      fault_in_q    <= fault_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.req_id;
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.level       = level_q;
  assign bus.busy        = busy_q;
  assign bus.active_id   = active_id_q;
  assign bus.logic_reset = logic_reset_q;
  assign bus.fault_in    = fault_in_q;
  assign bus.done        = done_q;
  assign bus.done_id     = done_id_q;
endmodule

// File: tb/tb_fault_trigger_sequencer.sv
// Bench for fault_trigger_sequencer: timeline table, directed corner sequences,
// and random traffic against a per-trigger age model.
module tb_fault_trigger_sequencer;
  localparam int DEPTH = 4;
  localparam int ID_W  = 4;
  localparam int S     = 2;
  localparam int H     = 3;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  fault_trigger_sequencer_if #(.ID_W(ID_W), .DEPTH(DEPTH)) bus ();

  fault_trigger_sequencer #(
    .DEPTH(DEPTH), .ID_W(ID_W), .SETTLE_CYC(S), .HOLD_CYC(H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: FIFO as a queue, in-flight trigger tracked by its age since pop.
  int mq[$];
  int m_id;
  int m_age;
  bit m_busy;
  bit m_done;
  int m_done_id;
  bit m_acc;
  int dq[$];
  int dc[$];

  typedef struct {
    bit v;
    int id;
    bit rdy;
    int lvl;
    bit busy;
    bit lr;
    bit fi;
    bit dn;
    int did;
    int aid;
  } vec_t;
  vec_t tbl[10];

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic check_model();
    cmp("req_ready", bus.req_ready, mq.size() != DEPTH);
    cmp("level", bus.level, mq.size());
    cmp("busy", bus.busy, m_busy);
    cmp("logic_reset", bus.logic_reset, m_busy && m_age == 1);
    cmp("fault_in", bus.fault_in, m_busy && m_age == S + 2);
    cmp("done", bus.done, m_done);
    if (m_done) cmp("done_id", bus.done_id, m_done_id);
    cmp("active_id", bus.active_id, m_busy ? m_id : 0);
  endtask

  task automatic step(input bit v, input int id, input bit fl, input bit rs);
    bit rdy_pre;
    bit can_pop;
    bus.req_valid = v;
    bus.req_id    = ID_W'(id);
    bus.flush     = fl;
    reset         = rs;
    @(posedge clk);
    cyc++;
    m_done  = 0;
    m_acc   = 0;
    rdy_pre = (mq.size() != DEPTH);
    can_pop = !m_busy && (mq.size() != 0);
    if (rs || fl) begin
      mq.delete();
      m_busy = 0;
    end else begin
      if (m_busy) begin
        m_age++;
        if (m_age == S + H + 2) begin
          m_done    = 1;
          m_done_id = m_id;
          m_busy    = 0;
        end
      end
      if (can_pop) begin
        m_id   = mq.pop_front();
        m_busy = 1;
        m_age  = 0;
      end
      if (v && rdy_pre) begin
        mq.push_back(id & 15);
        m_acc = 1;
      end
    end
    #1;
    check_model();
    if (bus.done) begin
      dq.push_back(int'(bus.done_id));
      dc.push_back(cyc);
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((bus.busy || bus.level != 0) && n < maxc) begin
      step(0, 0, 0, 0);
      n++;
    end
    if (bus.busy || bus.level != 0) cmp("drain_timeout", 1, 0);
  endtask

  initial begin
    int nxt;
    int n;
    int nfi;
    bit saw_full;
    bit seen_lr;
    bit seen_fi;
    int exp_ids[$];

    for (int k = 0; k < 10; k++) begin
      tbl[k].v    = (k == 0);
      tbl[k].id   = (k == 0) ? 5 : 0;
      tbl[k].rdy  = 1;
      tbl[k].lvl  = (k == 0) ? 1 : 0;
      tbl[k].busy = (k >= 1 && k <= 7);
      tbl[k].lr   = (k == 2);
      tbl[k].fi   = (k == 5);
      tbl[k].dn   = (k == 8);
      tbl[k].did  = (k == 8) ? 5 : 0;
      tbl[k].aid  = (k >= 1 && k <= 7) ? 5 : 0;
    end

    bus.req_valid = 0;
    bus.req_id    = '0;
    bus.flush     = 0;
    reset         = 1;
    m_busy = 0; m_age = 0; m_id = 0; m_done_id = 0;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    cmp("rst_req_ready", bus.req_ready, 1);
    cmp("rst_level", bus.level, 0);
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_lr", bus.logic_reset, 0);
    cmp("rst_fi", bus.fault_in, 0);
    cmp("rst_done", bus.done, 0);
    cmp("rst_active_id", bus.active_id, 0);

    // Single request timeline
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].v, tbl[k].id, 0, 0);
      cmp("tbl_ready", bus.req_ready, tbl[k].rdy);
      cmp("tbl_level", bus.level, tbl[k].lvl);
      cmp("tbl_busy", bus.busy, tbl[k].busy);
      cmp("tbl_lr", bus.logic_reset, tbl[k].lr);
      cmp("tbl_fi", bus.fault_in, tbl[k].fi);
      cmp("tbl_done", bus.done, tbl[k].dn);
      if (tbl[k].dn) cmp("tbl_done_id", bus.done_id, tbl[k].did);
      cmp("tbl_active_id", bus.active_id, tbl[k].aid);
    end

    // Back-to-back ids 1..4
    dq.delete(); dc.delete();
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
    drain(100);
    cmp("b2b_count", dq.size(), 4);
    for (int i = 0; i < dq.size() && i < 4; i++) cmp("b2b_order", dq[i], i + 1);
    for (int i = 1; i < dc.size(); i++) cmp("b2b_spacing", dc[i] - dc[i-1], 8);

    // Full FIFO with req_valid held
    dq.delete();
    nxt = 6; n = 0; saw_full = 0;
    while (exp_ids.size() < 8 && n < 200) begin
      step(1, nxt, 0, 0);
      if (m_acc) begin
        exp_ids.push_back(nxt);
        nxt++;
      end
      if (mq.size() == DEPTH) saw_full = 1;
      n++;
    end
    cmp("full_reached", saw_full, 1);
    drain(200);
    cmp("full_count", dq.size(), exp_ids.size());
    for (int i = 0; i < dq.size() && i < exp_ids.size(); i++) cmp("full_order", dq[i], exp_ids[i]);

    // Flush during SETTLE with two queued
    dq.delete();
    nfi = 0;
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    cmp("flush_level", bus.level, 0);
    cmp("flush_busy", bus.busy, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (bus.fault_in) nfi++;
    end
    cmp("flush_no_fault", nfi, 0);
    cmp("flush_no_done", dq.size(), 0);

    // Reset one cycle after fault_in, then a full replay
    step(1, 7, 0, 0);
    n = 0;
    while (!bus.fault_in && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
    cmp("rst_seq_fault_seen", bus.fault_in, 1);
    step(0, 0, 0, 1);
    cmp("midrst_ready", bus.req_ready, 1);
    cmp("midrst_busy", bus.busy, 0);
    cmp("midrst_level", bus.level, 0);
    cmp("midrst_fi", bus.fault_in, 0);
    cmp("midrst_done", bus.done, 0);
    cmp("midrst_active_id", bus.active_id, 0);
    step(0, 0, 0, 0);
    dq.delete();
    seen_lr = 0; seen_fi = 0;
    step(1, 9, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0);
      if (bus.logic_reset) seen_lr = 1;
      if (bus.fault_in) seen_fi = 1;
    end
    cmp("replay_lr", seen_lr, 1);
    cmp("replay_fi", seen_fi, 1);
    cmp("replay_done_count", dq.size(), 1);
    if (dq.size() > 0) cmp("replay_done_id", dq[0], 9);

    // Simultaneous push and pop at level 1
    drain(50);
    dq.delete();
    step(1, 10, 0, 0);
    step(1, 11, 0, 0);
    cmp("pp_level", bus.level, 1);
    drain(100);
    cmp("pp_count", dq.size(), 2);
    if (dq.size() == 2) begin
      cmp("pp_first", dq[0], 10);
      cmp("pp_second", dq[1], 11);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
